mem_access_master: RTL and testbench
====================================

Name: mem_access_master

Overview:
Load/store initiator that drives the byte-addressed data RAM port (word-wide, little-endian, combinational read, write on clock edge) on behalf of the core.
- Accepts one request at a time over a valid/ready handshake.
- Performs byte/half/word loads with sign or zero extension.
- Performs sub-word stores as read-modify-write, because the RAM only writes whole words.
- Checks alignment and range before any RAM access is issued.

Parameters:
MEM_SIZE, 8192, RAM size in bytes; valid byte addresses are 0..MEM_SIZE-1.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request; high only in IDLE.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and flags an error.
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_error  out  1  qualified by resp_valid; misaligned, out of range or illegal size.
mem_addr  out  32  RAM data_address; always word-aligned ({addr[31:2],2'b00}).
mem_read  out  1  RAM read strobe.
mem_write  out  1  RAM write strobe.
mem_wdata  out  32  RAM data_in.
mem_rdata  in  32  RAM data_out (combinational).

Behaviour:
- Reset:
  - State is IDLE and req_ready=1.
  - resp_valid, resp_error, mem_read and mem_write are 0.
  - resp_rdata, mem_addr and mem_wdata are 0.
- Request capture:
  - A handshake occurs when req_valid && req_ready at a rising edge.
  - All req_* fields are registered at that edge; req_* are ignored at every other time.
- Error check at acceptance:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - req_size=11 is an error.
  - req_addr >= MEM_SIZE is an error.
- States:
  - IDLE → ERR on an erroneous request.
  - IDLE → RD on a load or a sub-word store.
  - IDLE → WR on a word store.
  - RD → WR for a sub-word store; RD → RESP for a load.
  - WR → RESP.
  - RESP → IDLE; ERR → IDLE.
- RD:
  - mem_read=1 for exactly one cycle.
  - mem_rdata is captured into an internal word register at the end of the cycle.
- WR:
  - mem_write=1 for exactly one cycle.
  - mem_wdata is req_wdata for a word store, or the captured word with the target lanes replaced.
  - Byte store replaces lane addr[1:0] with wdata[7:0].
  - Half store replaces lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
- Strobes: mem_read and mem_write are never high together. mem_addr is stable from RD through WR.
- RESP:
  - resp_valid=1 and resp_error=0.
  - For loads, resp_rdata is the selected lane(s), extended per req_unsigned; word loads pass through unchanged.
- ERR:
  - resp_valid=1, resp_error=1, resp_rdata=0.
  - No RAM strobe is issued for the request.
- Latency, counted from the acceptance edge T:
  - Load: resp_valid at T+2.
  - Word store: resp_valid at T+2.
  - Sub-word store: resp_valid at T+3.
  - Error: resp_valid at T+1.
  - Next acceptance is possible one cycle after the RESP/ERR cycle.
- Reset mid-operation:
  - Aborts the access immediately; no mem_write is issued after rst_n falls.
  - The pending response is dropped and the block returns to the reset values.
- Outputs resp_* and mem_* are driven from registers or decoded from state only; there is no combinational path from req_* to any output.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state enumeration IDLE/RD/WR/RESP/ERR.
- One combinational sub-module, mem_lane_align, holds:
  - lane extract with sign/zero extension;
  - store lane merge.
- The FSM and registers stay in mem_access_master.

Test Plan:
1. Word store 0xDEADBEEF to 0x100 → mem_write=1 at T+1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF; resp_valid at T+2 with error=0. Then a word load from 0x100 → resp_rdata=0xDEADBEEF at T+2.
2. With word 0x100=0xDEADBEEF:
   - signed byte load at 0x103 → 0xFFFFFFDE;
   - unsigned byte load at 0x103 → 0x000000DE;
   - signed half load at 0x100 → 0xFFFFBEEF;
   - unsigned half load at 0x102 → 0x0000DEAD.
3. Byte store 0x55 to 0x101 → mem_read at T+1, mem_write at T+2 with mem_wdata=0xDEAD55EF, resp_valid at T+3. A following word load returns 0xDEAD55EF.
4. Error requests each give resp_valid with resp_error=1 at T+1 and no mem_read/mem_write at any point:
   - word load at 0x102;
   - half store at 0x101;
   - word load at 0x2000;
   - size 11.
5. Assert rst_n=0 during the RD cycle of a byte store → mem_write is never asserted and resp_valid stays 0. After release req_ready=1, and a word load returns the unchanged word.
6. req_valid held high with two back-to-back word loads → the second is accepted at T+3; each response carries its own data; req_ready=0 during RD and RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store initiator: access sizes and FSM states.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension and
// sub-word store merge into a previously read word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        load_data  = rdata;
        store_word = wdata;
        byte_v     = 8'(rdata >> {lane, 3'b000});
        half_v     = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_B: begin
                load_data  = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
                store_word = rdata;
                store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data  = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
                store_word = rdata;
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data  = rdata;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Load/store initiator for a word-wide byte-addressed RAM; sub-word stores
// are done as read-modify-write, errors are caught before any RAM access.
module mem_access_master
    import mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    mem_lane_align u_align (
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .size       (size_q),
        .uns        (uns_q),
        .lane       (lane_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Alignment, size and range check on the incoming request.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SIZE_B:  req_err = 1'b0;
            SIZE_H:  req_err = req_addr[0];
            SIZE_W:  req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_addr >= 32'(MEM_SIZE)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = 32'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    lane_d      = req_addr[1:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = req_wdata;
                    if (req_err) begin
                        state_d = ERR;
                    end else if (req_write && (req_size == SIZE_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Word captured here feeds both the load result and the merge.
                mem_wdata_d  = store_word;
                resp_rdata_d = write_q ? 32'b0 : load_data;
                state_d      = write_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_read   = (state_q == RD);
    assign mem_write  = (state_q == WR);
    assign resp_valid = (state_q == RESP) || (state_q == ERR);
    assign resp_error = (state_q == ERR);
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed vector bench for mem_access_master with a behavioural RAM.
module tb_mem_access_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram [2048];

    mem_access_master #(.MEM_SIZE(8192)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[12:2]];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[12:2]] <= mem_wdata;
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // One request: drive at negedge, accept at the next posedge, sample #1 after each edge.
    task automatic run_vec(input vec_t v);
        int lat;
        int nrd;
        int nwr;
        logic [31:0] wd;
        logic addr_ok;
        logic excl_ok;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
        lat = 1; nrd = 0; nwr = 0; wd = 32'b0; addr_ok = 1'b1; excl_ok = 1'b1;
        check({v.name, "/busy_ready"}, 32'(req_ready), 32'd0);
        while (!resp_valid && lat < 8) begin
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wd = mem_wdata; end
            if (mem_read && mem_write) excl_ok = 1'b0;
            if ((mem_read || mem_write) && mem_addr !== {v.addr[31:2], 2'b00}) addr_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (mem_read) nrd++;
        if (mem_write) nwr++;
        check({v.name, "/latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, "/error"}, 32'(resp_error), 32'(v.exp_err));
        check({v.name, "/rdata"}, resp_rdata, v.exp_rdata);
        check({v.name, "/reads"}, 32'(nrd), 32'(v.exp_rd));
        check({v.name, "/writes"}, 32'(nwr), 32'(v.exp_wr));
        check({v.name, "/addr"}, 32'(addr_ok), 32'd1);
        check({v.name, "/excl"}, 32'(excl_ok), 32'd1);
        if (v.exp_wr != 0) check({v.name, "/wdata"}, wd, v.exp_wdata);
        @(posedge clk); #1;
        check({v.name, "/idle_ready"}, 32'(req_ready), 32'd1);
        check({v.name, "/idle_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;

        //       name        wr size   uns addr          wdata          exp_rdata      err lat rd wr exp_wdata
        vecs.push_back(mk("sw",   1, 2'b10, 0, 32'h100,  32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk("lw",   0, 2'b10, 0, 32'h100,  32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lb",   0, 2'b00, 0, 32'h103,  32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lbu",  0, 2'b00, 1, 32'h103,  32'h0,        32'h000000DE, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lh",   0, 2'b01, 0, 32'h100,  32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lhu",  0, 2'b01, 1, 32'h102,  32'h0,        32'h0000DEAD, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("sb",   1, 2'b00, 0, 32'h101,  32'hAAAAAA55, 32'h0,        0, 3, 1, 1, 32'hDEAD55EF));
        vecs.push_back(mk("lw2",  0, 2'b10, 0, 32'h100,  32'h0,        32'hDEAD55EF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("sh",   1, 2'b01, 0, 32'h102,  32'hBBBB1234, 32'h0,        0, 3, 1, 1, 32'h123455EF));
        vecs.push_back(mk("lw3",  0, 2'b10, 0, 32'h100,  32'h0,        32'h123455EF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lb0",  0, 2'b00, 0, 32'h100,  32'h0,        32'hFFFFFFEF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("lbp",  0, 2'b00, 0, 32'h101,  32'h0,        32'h00000055, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("swtop",1, 2'b10, 0, 32'h1FFC, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 32'hCAFEF00D));
        vecs.push_back(mk("lwtop",0, 2'b10, 0, 32'h1FFC, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk("e_lw", 0, 2'b10, 0, 32'h102,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk("e_sh", 1, 2'b01, 0, 32'h101,  32'h12345678, 32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk("e_rng",0, 2'b10, 0, 32'h2000, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk("e_rgb",1, 2'b00, 0, 32'h2000, 32'h11,       32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk("e_sz", 0, 2'b11, 0, 32'h100,  32'h0,        32'h0,        1, 1, 0, 0, 32'h0));

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst/ready", 32'(req_ready), 32'd1);
        check("rst/strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
        check("rst/error", 32'(resp_error), 32'd0);
        check("rst/rdata", resp_rdata, 32'd0);
        check("rst/maddr", mem_addr, 32'd0);
        check("rst/mwdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the RD cycle of a byte store: the write must never happen.
        begin
            int bad_wr;
            int bad_rv;
            bad_wr = 0; bad_rv = 0;
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
            req_addr = 32'h100; req_wdata = 32'h77;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("rstmid/in_rd", 32'(mem_read), 32'd1);
            rst_n = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (mem_write) bad_wr++;
                if (resp_valid) bad_rv++;
                @(posedge clk);
            end
            #1;
            check("rstmid/no_write", 32'(bad_wr), 32'd0);
            check("rstmid/no_resp", 32'(bad_rv), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("rstmid/ready", 32'(req_ready), 32'd1);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                if (mem_write || resp_valid) bad_wr++;
            end
            check("rstmid/quiet", 32'(bad_wr), 32'd0);
        end
        run_vec(mk("rstmid/lw", 0, 2'b10, 0, 32'h100, 32'h0, 32'h123455EF, 0, 2, 1, 0, 32'h0));

        // Back-to-back word loads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100;
        @(posedge clk); #1;
        req_addr = 32'h1FFC;
        check("b2b/t1_ready", 32'(req_ready), 32'd0);
        check("b2b/t1_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        check("b2b/t2_valid", 32'(resp_valid), 32'd1);
        check("b2b/t2_ready", 32'(req_ready), 32'd0);
        check("b2b/t2_rdata", resp_rdata, 32'h123455EF);
        @(posedge clk); #1;
        check("b2b/t3_ready", 32'(req_ready), 32'd1);
        check("b2b/t3_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b/t4_read", 32'(mem_read), 32'd1);
        check("b2b/t4_addr", mem_addr, 32'h1FFC);
        @(posedge clk); #1;
        check("b2b/t5_valid", 32'(resp_valid), 32'd1);
        check("b2b/t5_rdata", resp_rdata, 32'hCAFEF00D);
        check("b2b/t5_error", 32'(resp_error), 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
